// File: rtl/regfile_arb_pkg.sv
// Shared encodings and default widths for the register-file arbiter.
// The FSM states and owner codes are consumed by regfile_arbiter and regfile_arb_pick.
package regfile_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

endpackage

// File: rtl/regfile_arb_pick.sv
// Core-first request picker with a starvation counter.
// After STARVE_LIMIT core grants with debug waiting, debug gets a turn.
module regfile_arb_pick
  import regfile_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic core_req,
  input  logic dbg_req,
  output logic grant_core,
  output logic grant_dbg,
  output logic any_grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starveCnt;
  logic       w_starved;

  always_comb begin
    w_starved  = dbg_req && (r_starveCnt == LIMIT);
    grant_dbg  = arb_en && dbg_req && (!core_req || w_starved);
    grant_core = arb_en && core_req && !grant_dbg;
    any_grant  = grant_core || grant_dbg;
  end

  // Counter only moves at arbitration points; it counts core wins debug had to sit through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starveCnt <= 4'd0;
    end else if (arb_en) begin
      if (grant_dbg || !dbg_req) begin
        r_starveCnt <= 4'd0;
      end else if (grant_core) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the en/register_done register-file handshake between the core and the debug port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_ra1,
  input  logic [ADDR_W-1:0] core_ra2,
  input  logic [ADDR_W-1:0] core_wa,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd1,
  output logic [DATA_W-1:0] core_rd2,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rd,
  output logic              rf_en,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              rf_done,
  output logic              busy
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  owner_e     r_owner;
  logic [7:0] r_waitCnt;
  logic       w_grantCore;
  logic       w_grantDbg;
  logic       w_anyGrant;

  regfile_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (r_state == ST_IDLE),
    .core_req  (core_req),
    .dbg_req   (dbg_req),
    .grant_core(w_grantCore),
    .grant_dbg (w_grantDbg),
    .any_grant (w_anyGrant)
  );

  // Acks and rf_en are single-cycle pulses; everything else holds until next written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_CORE;
      r_waitCnt     <= 8'd0;
      core_ack      <= 1'b0;
      core_err      <= 1'b0;
      core_rd1      <= '0;
      core_rd2      <= '0;
      dbg_ack       <= 1'b0;
      dbg_err       <= 1'b0;
      dbg_rd        <= '0;
      rf_en         <= 1'b0;
      rf_reg_write  <= 1'b0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      busy          <= 1'b0;
    end else begin
      core_ack <= 1'b0;
      dbg_ack  <= 1'b0;
      rf_en    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyGrant) begin
            if (w_grantCore) begin
              r_owner       <= OWN_CORE;
              rf_reg_write  <= core_we;
              rf_read_reg1  <= core_ra1;
              rf_read_reg2  <= core_ra2;
              rf_write_reg  <= core_wa;
              rf_write_data <= core_wd;
            end else begin
              r_owner       <= OWN_DBG;
              rf_reg_write  <= dbg_we;
              rf_read_reg1  <= dbg_addr;
              rf_read_reg2  <= dbg_addr;
              rf_write_reg  <= dbg_addr;
              rf_write_data <= dbg_wd;
            end
            r_waitCnt <= 8'd0;
            rf_en     <= 1'b1;
            busy      <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A timeout completes like a normal transaction but with err set and zeroed data.
          if (rf_done || (r_waitCnt == WAIT_LAST)) begin
            if (r_owner == OWN_CORE) begin
              core_ack <= 1'b1;
              core_err <= !rf_done;
              core_rd1 <= rf_done ? rf_read_data1 : '0;
              core_rd2 <= rf_done ? rf_read_data2 : '0;
            end else begin
              dbg_ack <= 1'b1;
              dbg_err <= !rf_done;
              dbg_rd  <= rf_done ? rf_read_data1 : '0;
            end
            r_state <= ST_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Shares the single-ported-handshake register file between two requesters: the core datapath (primary) and the board debug/loader port (secondary). Sequences the register file's en / register_done handshake, latches one request at a time, returns read data and a one-cycle ack to the owner. Sits between the core control unit, the debug port and the RegisterFile instance.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
STARVE_LIMIT, 4, consecutive core grants allowed while dbg_req is pending (range 1..15)
TIMEOUT, 8, max cycles in WAIT for rf_done before an error completion (range 2..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
core_req  in  1  core request; held until core_ack
core_we  in  1  core write enable
core_ra1  in  ADDR_W  core read address 1
core_ra2  in  ADDR_W  core read address 2
core_wa  in  ADDR_W  core write address
core_wd  in  DATA_W  core write data
core_ack  out  1  one-cycle completion pulse
core_err  out  1  valid with core_ack; 1 = timeout
core_rd1  out  DATA_W  read data 1, valid while core_ack
core_rd2  out  DATA_W  read data 2, valid while core_ack
dbg_req  in  1  debug request; held until dbg_ack
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug read and write address
dbg_wd  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_err  out  1  valid with dbg_ack; 1 = timeout
dbg_rd  out  DATA_W  read data, valid while dbg_ack
rf_en  out  1  register file enable
rf_reg_write  out  1  register file write enable
rf_read_reg1  out  ADDR_W  to register file
rf_read_reg2  out  ADDR_W  to register file
rf_write_reg  out  ADDR_W  to register file
rf_write_data  out  DATA_W  to register file
rf_read_data1  in  DATA_W  from register file
rf_read_data2  in  DATA_W  from register file
rf_done  in  1  register file register_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs and internal registers go to 0 asynchronously. FSM goes to IDLE. Starvation counter is cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - On any req, the picker selects an owner.
  - The owner's fields are latched into the rf_* command registers. For a debug grant, dbg_addr drives rf_read_reg1, rf_read_reg2 and rf_write_reg.
  - Next state is ISSUE.
- ISSUE: rf_en=1 for exactly this one cycle. Next state is WAIT.
- WAIT:
  - rf_en=0.
  - If rf_done=1, capture rf_read_data1/2 into the owner's rd registers and go to DONE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, go to DONE with err=1 and rd=0.
- DONE: the owner's ack=1 and err is valid for this one cycle. The other requester's ack stays 0. Next state is IDLE.
- Latency: req sampled at edge 0 -> ack high in cycle 3. One transaction per 4 cycles maximum.
- Read-before-write: a read of the address being written in the same transaction returns the old value.
- Writes to address 0 pass through unfiltered. The register file ignores them.
- Arbitration:
  - Core wins ties.
  - The starvation counter increments on each core grant made while dbg_req=1.
  - When the counter equals STARVE_LIMIT and dbg_req=1, debug is granted and the counter clears.
  - The counter also clears on any debug grant, or when dbg_req=0 at arbitration.
- A req still high in IDLE after its ack is treated as a new request.
- Command fields are latched at grant, so requester input changes after grant have no effect.
- Reset during ISSUE, WAIT or DONE:
  - The transaction is abandoned and no ack is issued.
  - A write whose ISSUE-cycle clock edge has not occurred is dropped.
  - Register file contents are not reset by this block.
- rf_done rising outside WAIT is ignored.

Decomposition:
- Shared package regfile_arb_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3)
  - owner encoding (OWN_CORE=0, OWN_DBG=1)
  - default widths
- One sub-module, regfile_arb_pick, contains the combinational priority/starvation pick and the registered starvation counter. Its outputs are grant_core, grant_dbg and any_grant.

Test Plan:
1. Core write r5=32'hDEADBEEF, then core read ra1=5, ra2=0 -> first ack in cycle 3 with err=0; second ack rd1=32'hDEADBEEF, rd2=0.
2. core_req and dbg_req both rise in the same cycle (single-shot, held until each ack) -> core_ack in cycle 3, dbg_ack in cycle 7, never both high together.
3. core_req held high continuously, dbg_req held, STARVE_LIMIT=4 -> grant order C,C,C,C,D,C,... with dbg_ack after the 5th transaction.
4. Debug write r0=32'h12345678, then debug read r0 -> dbg_rd=0, dbg_err=0.
5. rf_done tied 0, core read, TIMEOUT=8 -> core_ack with core_err=1 and rd1=rd2=0 after 8 WAIT cycles; FSM back in IDLE; busy falls.
6. rst pulsed during WAIT of a core write to r7 -> rf_en, acks and busy are 0 immediately; no ack is issued. After release, a core read of r7 completes normally in 3 cycles.
